// File: rtl/hpdcache_fifo_rd_serializer_pkg.sv
// ============================================================================
//  Module  : hpdcache_fifo_rd_serializer_pkg
//  Brief   : Shared state encoding for the FIFO read-side serializer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hpdcache_fifo_rd_serializer_pkg;

    // Serializer FSM encoding: IDLE waits for an entry, SEND streams its beats.
    localparam logic [0:0] SER_IDLE = 1'b0;
    localparam logic [0:0] SER_SEND = 1'b1;

endpackage

`default_nettype wire

// File: rtl/hpdcache_fifo_rd_serializer.sv
// ============================================================================
//  Module  : hpdcache_fifo_rd_serializer
//  Brief   : Pops wide entries from a register FIFO and streams each one as
//            NBEATS narrow beats on a valid/ready interface, chaining the next
//            pop onto the last-beat handshake so consecutive entries flow
//            without bubbles.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_fifo_rd_serializer
    import hpdcache_fifo_rd_serializer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BEAT_WIDTH = 16,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       fifo_rok_i,
    output logic                                       fifo_r_o,
    input  logic [DATA_WIDTH-1:0]                      fifo_rdata_i,
    output logic                                       beat_valid_o,
    input  logic                                       beat_ready_i,
    output logic [BEAT_WIDTH-1:0]                      beat_data_o,
    output logic                                       beat_first_o,
    output logic                                       beat_last_o,
    output logic [$clog2(DATA_WIDTH/BEAT_WIDTH)-1:0]   beat_idx_o,
    output logic                                       busy_o
);

    localparam int unsigned NBEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int unsigned IDX_W  = $clog2(NBEATS);

    typedef logic [IDX_W-1:0] beat_idx_t;

    localparam beat_idx_t LAST_IDX = beat_idx_t'(NBEATS - 1);

    // Reject geometries that cannot be split into at least two whole beats.
    if ((DATA_WIDTH % BEAT_WIDTH) != 0) begin : g_chk_multiple
        $error("DATA_WIDTH must be an integer multiple of BEAT_WIDTH");
    end
    if (NBEATS < 2) begin : g_chk_nbeats
        $error("DATA_WIDTH/BEAT_WIDTH must be at least 2");
    end

    logic [0:0]            state_q, state_d;
    beat_idx_t             cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] buf_q;

    logic      send;
    logic      last;
    logic      hs;
    logic      pop;
    beat_idx_t slice;

    assign send = (state_q == SER_SEND);
    assign last = (cnt_q == LAST_IDX);
    assign hs   = send & beat_ready_i;

    // A pop is allowed from IDLE, or chained onto the final beat's handshake;
    // gating with rst_ni keeps the FIFO untouched while reset is held.
    assign pop      = rst_ni & fifo_rok_i & (~send | (hs & last));
    assign fifo_r_o = pop;

    // Physical slice position of the current beat inside the holding register.
    if (MSB_FIRST) begin : g_msb_first
        assign slice = LAST_IDX - cnt_q;
    end else begin : g_lsb_first
        assign slice = cnt_q;
    end

    // Select the current beat out of the holding register.
    always_comb begin
        beat_data_o = '0;
        for (int k = 0; k < int'(NBEATS); k++) begin
            if (slice == beat_idx_t'(k)) begin
                beat_data_o = buf_q[k*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Next-state logic: wrap is explicit at LAST_IDX so non power-of-two
    // beat counts never rely on counter overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pop) begin
            state_d = SER_SEND;
            cnt_d   = '0;
        end else if (hs) begin
            if (last) begin
                state_d = SER_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + beat_idx_t'(1);
            end
        end
    end

    // FSM state and beat counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding register captures the FIFO head on every pop; contents are
    // irrelevant until the first pop, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            buf_q <= fifo_rdata_i;
        end
    end

    assign beat_valid_o = send;
    assign busy_o       = send;
    assign beat_first_o = (cnt_q == '0);
    assign beat_last_o  = last;
    assign beat_idx_o   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_fifo_rd_serializer.sv
// ============================================================================
//  Module  : tb_hpdcache_fifo_rd_serializer
//  Brief   : Self-checking bench for the FIFO read-side serializer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpdcache_fifo_rd_serializer;

    logic clk = 1'b0;
    logic rst_n;

    // 32/8 LSB-first instance
    logic        rok, fifo_r, valid, ready, first, last, busy;
    logic [31:0] rdata;
    logic [7:0]  bdata;
    logic [1:0]  idx;

    // 48/16 MSB-first instance
    logic        rok6, fifo_r6, valid6, ready6, first6, last6, busy6;
    logic [47:0] rdata6;
    logic [15:0] bdata6;
    logic [1:0]  idx6;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] d;
        int         i;
    } beat_t;

    always #5 clk = ~clk;

    hpdcache_fifo_rd_serializer #(
        .DATA_WIDTH(32), .BEAT_WIDTH(8), .MSB_FIRST(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .fifo_rok_i(rok), .fifo_r_o(fifo_r),
        .fifo_rdata_i(rdata), .beat_valid_o(valid), .beat_ready_i(ready),
        .beat_data_o(bdata), .beat_first_o(first), .beat_last_o(last),
        .beat_idx_o(idx), .busy_o(busy)
    );

    hpdcache_fifo_rd_serializer #(
        .DATA_WIDTH(48), .BEAT_WIDTH(16), .MSB_FIRST(1'b1)
    ) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .fifo_rok_i(rok6), .fifo_r_o(fifo_r6),
        .fifo_rdata_i(rdata6), .beat_valid_o(valid6), .beat_ready_i(ready6),
        .beat_data_o(bdata6), .beat_first_o(first6), .beat_last_o(last6),
        .beat_idx_o(idx6), .busy_o(busy6)
    );

    // Reset values while reset is held and on the first cycle after release.
    task automatic test_reset();
        rst_n = 1'b0; rok = 1'b1; rdata = 32'h0; ready = 1'b1;
        rok6 = 1'b1; rdata6 = 48'h0; ready6 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({valid, busy, idx, first, last} !== {1'b0, 1'b0, 2'd0, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL reset_state: got v/b/idx/f/l=%b%b%0d%b%b want 00 0 10", valid, busy, idx, first, last);
            end
            n_cmp++;
            if (fifo_r !== 1'b0 || fifo_r6 !== 1'b0) begin
                n_err++;
                $display("FAIL reset_no_pop: got fifo_r=%b fifo_r6=%b want 0", fifo_r, fifo_r6);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; rok = 1'b0; rok6 = 1'b0; #1;
        n_cmp++;
        if ({valid, busy, idx, first, last, fifo_r} !== {1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset: got v/b/idx/f/l/r=%b%b%0d%b%b%b want 00 0 100", valid, busy, idx, first, last, fifo_r);
        end
    endtask

    // One entry, ready held high: beats on the 4 cycles after the pop.
    task automatic test_single();
        logic [31:0] e = 32'hDDCCBBAA;
        @(negedge clk);
        rok = 1'b1; rdata = e; ready = 1'b1; #1;
        n_cmp++;
        if (fifo_r !== 1'b1 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pop: got fifo_r=%b valid=%b want 1 0", fifo_r, valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rok = 1'b0; #1;
            n_cmp++;
            if ({valid, busy, bdata, idx, first, last, fifo_r} !==
                {1'b1, 1'b1, e[8*k +: 8], 2'(k), k == 0, k == 3, 1'b0}) begin
                n_err++;
                $display("FAIL single_beat%0d: got v=%b d=%h idx=%0d f=%b l=%b r=%b want d=%h idx=%0d", k, valid, bdata, idx, first, last, fifo_r, e[8*k +: 8], k);
            end
        end
        @(negedge clk); #1;
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_end: got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    // Two queued entries stream as 8 gapless beats.
    task automatic test_back_to_back();
        logic [63:0] ents = {32'h88776655, 32'h44332211};
        @(negedge clk);
        rok = 1'b1; rdata = ents[31:0]; ready = 1'b1; #1;
        n_cmp++;
        if (fifo_r !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_pop0: got fifo_r=%b want 1", fifo_r);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rok = (k < 4); rdata = ents[63:32]; #1;
            n_cmp++;
            if ({valid, bdata, idx, first, last} !== {1'b1, ents[8*k +: 8], 2'(k % 4), (k % 4) == 0, (k % 4) == 3}) begin
                n_err++;
                $display("FAIL b2b_beat%0d: got v=%b d=%h idx=%0d f=%b l=%b want d=%h", k, valid, bdata, idx, first, last, ents[8*k +: 8]);
            end
            n_cmp++;
            if (fifo_r !== (k == 3)) begin
                n_err++;
                $display("FAIL b2b_pop_at%0d: got fifo_r=%b want %b", k, fifo_r, k == 3);
            end
        end
        @(negedge clk); rok = 1'b0; #1;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got valid=%b want 0", valid);
        end
    endtask

    // Ready low for 3 cycles on beat BB: outputs frozen, no pop.
    task automatic test_backpressure();
        logic [31:0] e = 32'hDDCCBBAA;
        @(negedge clk);
        rok = 1'b1; rdata = e; ready = 1'b1;
        @(negedge clk);
        rok = 1'b1; rdata = 32'h12345678; #1;
        n_cmp++;
        if (bdata !== 8'hAA) begin
            n_err++;
            $display("FAIL bp_beat0: got %h want aa", bdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ready = 1'b0; #1;
            n_cmp++;
            if ({valid, bdata, idx, fifo_r} !== {1'b1, 8'hBB, 2'd1, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b d=%h idx=%0d r=%b want 1 bb 1 0", c, valid, bdata, idx, fifo_r);
            end
        end
        @(negedge clk);
        ready = 1'b1; rok = 1'b0; #1;
        n_cmp++;
        if ({valid, bdata, idx} !== {1'b1, 8'hBB, 2'd1}) begin
            n_err++;
            $display("FAIL bp_release: got v=%b d=%h idx=%0d want 1 bb 1", valid, bdata, idx);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({valid, bdata, idx} !== {1'b1, 8'hCC, 2'd2}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b d=%h idx=%0d want 1 cc 2", valid, bdata, idx);
        end
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_end: got valid=%b want 0", valid);
        end
    endtask

    // rok low on last beat: back to IDLE, later pop at T gives beat 0 at T+1.
    task automatic test_rok_low();
        logic [31:0] e2 = 32'hF4F3F2F1;
        @(negedge clk);
        rok = 1'b1; rdata = 32'hA4A3A2A1; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); rok = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({valid, busy, fifo_r} !== 3'b000) begin
                n_err++;
                $display("FAIL roklow_idle%0d: got v/b/r=%b%b%b want 000", c, valid, busy, fifo_r);
            end
        end
        @(negedge clk);
        rok = 1'b1; rdata = e2; #1;
        n_cmp++;
        if (fifo_r !== 1'b1 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL roklow_popT: got fifo_r=%b valid=%b want 1 0", fifo_r, valid);
        end
        @(negedge clk);
        rok = 1'b0; #1;
        n_cmp++;
        if ({valid, bdata, idx, first} !== {1'b1, 8'hF1, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL roklow_beat0: got v=%b d=%h idx=%0d f=%b want 1 f1 0 1", valid, bdata, idx, first);
        end
        for (int k = 1; k < 4; k++) @(negedge clk);
    endtask

    // Reset after beat BB: entry dropped, next entry restarts at beat 0.
    task automatic test_reset_mid();
        @(negedge clk);
        rok = 1'b1; rdata = 32'hDDCCBBAA; ready = 1'b1;
        @(negedge clk); rok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; rok = 1'b1; rdata = 32'h55555555; #1;
        n_cmp++;
        if (fifo_r !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_nopop: got fifo_r=%b want 0", fifo_r);
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({valid, busy, idx, fifo_r} !== {1'b0, 1'b0, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid_state: got v/b/idx/r=%b%b %0d %b want 00 0 0", valid, busy, idx, fifo_r);
        end
        @(negedge clk);
        rst_n = 1'b1; rdata = 32'h9C9B9A99; #1;
        n_cmp++;
        if (fifo_r !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pop: got fifo_r=%b want 1", fifo_r);
        end
        @(negedge clk);
        rok = 1'b0; #1;
        n_cmp++;
        if ({valid, bdata, idx, first} !== {1'b1, 8'h99, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rstmid_beat0: got v=%b d=%h idx=%0d f=%b want 1 99 0 1", valid, bdata, idx, first);
        end
        for (int k = 1; k < 4; k++) @(negedge clk);
    endtask

    // Random FIFO occupancy and backpressure against a beat-queue model.
    task automatic test_random();
        logic [31:0] fq[$];
        beat_t       exp_q[$];
        beat_t       e;
        logic        have_prev = 1'b0;
        logic [9:0]  prev = '0;
        logic        hs, exp_pop;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (fq.size() < 2) fq.push_back($urandom);
            rok   = ($urandom_range(0, 3) != 0);
            rdata = fq[0];
            ready = ($urandom_range(0, 2) != 0);
            #1;
            n_cmp++;
            if (valid !== (exp_q.size() != 0) || busy !== (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_valid c%0d: got valid=%b busy=%b want %b", c, valid, busy, exp_q.size() != 0);
            end
            if (have_prev) begin
                n_cmp++;
                if ({bdata, idx} !== prev || valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_stable c%0d: got v=%b d/idx=%h want 1 %h", c, valid, {bdata, idx}, prev);
                end
            end
            hs = (exp_q.size() != 0) && ready;
            if (hs) begin
                e = exp_q[0];
                n_cmp++;
                if ({bdata, idx, first, last} !== {e.d, 2'(e.i), e.i == 0, e.i == 3}) begin
                    n_err++;
                    $display("FAIL rand_beat c%0d: got d=%h idx=%0d f=%b l=%b want d=%h idx=%0d", c, bdata, idx, first, last, e.d, e.i);
                end
            end
            exp_pop = rok && (exp_q.size() == 0 || (exp_q.size() == 1 && ready));
            n_cmp++;
            if (fifo_r !== exp_pop) begin
                n_err++;
                $display("FAIL rand_pop c%0d: got fifo_r=%b want %b", c, fifo_r, exp_pop);
            end
            have_prev = (exp_q.size() != 0) && !ready;
            prev      = {bdata, idx};
            if (hs) void'(exp_q.pop_front());
            if (exp_pop) begin
                for (int k = 0; k < 4; k++) begin
                    e.d = 8'((fq[0] >> (8 * k)) & 32'hFF);
                    e.i = k;
                    exp_q.push_back(e);
                end
                void'(fq.pop_front());
            end
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            rok = 1'b0; ready = 1'b1; #1;
            e = exp_q[0];
            n_cmp++;
            if ({valid, bdata, idx} !== {1'b1, e.d, 2'(e.i)}) begin
                n_err++;
                $display("FAIL rand_drain: got v=%b d=%h idx=%0d want 1 %h %0d", valid, bdata, idx, e.d, e.i);
            end
            void'(exp_q.pop_front());
        end
        @(negedge clk); #1;
        n_cmp++;
        if (valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_end: got valid=%b pending=%0d want 0 0", valid, exp_q.size());
        end
    endtask

    // MSB-first, NBEATS=3: slice order and index wrap 2->0 across entries.
    task automatic test_msb_first();
        logic [95:0] ents = {48'h333322221111, 48'hCCCCBBBBAAAA};
        logic [47:0] cur;
        @(negedge clk);
        rok6 = 1'b1; rdata6 = ents[47:0]; ready6 = 1'b1; #1;
        n_cmp++;
        if (fifo_r6 !== 1'b1) begin
            n_err++;
            $display("FAIL msb_pop: got fifo_r6=%b want 1", fifo_r6);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rok6 = (k < 3); rdata6 = ents[95:48]; #1;
            cur = (k < 3) ? ents[47:0] : ents[95:48];
            n_cmp++;
            if ({valid6, bdata6, idx6, first6, last6} !==
                {1'b1, cur[16*(2 - k % 3) +: 16], 2'(k % 3), (k % 3) == 0, (k % 3) == 2}) begin
                n_err++;
                $display("FAIL msb_beat%0d: got v=%b d=%h idx=%0d f=%b l=%b want d=%h idx=%0d", k, valid6, bdata6, idx6, first6, last6, cur[16*(2 - k % 3) +: 16], k % 3);
            end
        end
        @(negedge clk); rok6 = 1'b0; #1;
        n_cmp++;
        if (valid6 !== 1'b0 || busy6 !== 1'b0) begin
            n_err++;
            $display("FAIL msb_end: got valid6=%b busy6=%b want 0 0", valid6, busy6);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_rok_low();
        test_reset_mid();
        test_random();
        test_msb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
